vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 128 ++++++++++++
 tb/tb_vga_timing.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator for the DE1-SoC video DAC: 25 MHz pixel tick from clock_50,
// coordinate requests one pixel ahead of the video outputs. Optional colour bars: VGA_TEST_PATTERN_EN.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_req,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam logic [9:0] H_VISIBLE    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VISIBLE    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    // Request contract: pixel_x/pixel_y/pixel_req are held for a whole pixel period; the
    // client returns the colour on rgb_in before that period ends, and the colour is
    // captured together with the syncs on the tick that closes the period.
    logic        tick;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic [23:0] colour;

    // h_count/v_count hold the coordinate to be presented on the next tick.
    always_comb begin
        h_next = h_count + 10'd1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    function automatic logic [23:0] bar_colour(input logic [9:0] x);
        logic [2:0]  idx;
        logic [23:0] c;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * BAR_W)) idx = 3'(i);
        end
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic unused_rgb_in;
    assign unused_rgb_in = ^rgb_in;
    assign colour        = bar_colour(pixel_x);
`else
    assign colour = rgb_in;
`endif

    always_ff @(posedge clock_50) begin
        if (reset) begin
            tick        <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_req   <= 1'b0;
            frame_start <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK   <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            tick        <= ~tick;
            frame_start <= 1'b0;
            if (tick) begin
                h_count     <= h_next;
                v_count     <= v_next;
                pixel_x     <= h_count;
                pixel_y     <= v_count;
                pixel_req   <= (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
                frame_start <= (h_count == '0) && (v_count == '0);
                // Video side works on the coordinate whose request period is ending now.
                VGA_HS      <= !((pixel_x >= H_SYNC_START) && (pixel_x <= H_SYNC_END));
                VGA_VS      <= !((pixel_y >= V_SYNC_START) && (pixel_y <= V_SYNC_END));
                VGA_BLANK   <= pixel_req;
                VGA_R       <= pixel_req ? colour[23:16] : 8'h00;
                VGA_G       <= pixel_req ? colour[15:8]  : 8'h00;
                VGA_B       <= pixel_req ? colour[7:0]   : 8'h00;
            end
        end
    end

    assign VGA_CLK  = tick;
    assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: arithmetic raster model compared every clock,
// plus literal checks of reset, line/frame timing, colour path and mid-frame reset.
module tb_vga_timing;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 10;
    localparam int V_FRONT  = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 2;
    localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic        clock_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [23:0] rgb_in   = '0;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_req;
    logic        frame_start;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK;
    logic        VGA_SYNC;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int cyc    = 0;
    int mode   = 0;
    logic chk_en = 1'b0;
    logic seen_a = 1'b0;
    logic seen_b = 1'b0;
    logic [23:0] prev_rgb = '0;
    logic [23:0] held_rgb = '0;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) dut (
        .clock_50(clock_50), .reset(reset), .rgb_in(rgb_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
        .frame_start(frame_start), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    // clock / reset-relative time
    always #5 clock_50 = ~clock_50;

    always @(posedge clock_50) begin
        cyc <= cyc + 1;
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [23:0] bar_ref(input int x);
        case (x / 80)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return VGA_HS;
            1:       return VGA_VS;
            2:       return VGA_BLANK;
            default: return frame_start;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic lvl, input int budget, input string name,
                            output int t);
        int i;
        i = 0;
        while (sig(sel) !== lvl && i < budget) begin
            @(negedge clock_50);
            i++;
        end
        t = cyc;
        if (sig(sel) !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d clocks", name, budget);
        end
    endtask

    // driver: rgb_in either encodes the requested coordinate or is random
    initial begin
        forever begin
            @(posedge clock_50);
            #2;
            if (mode == 0) rgb_in = {pixel_x[7:0], pixel_y[7:0], 8'hA5};
            else           rgb_in = 24'($urandom);
        end
    end

    // scoreboard: raster position derived from clocks elapsed since reset release
    int k, p, ex, ey, d, dx, dy;
    logic e_req, e_fs, e_clk, e_hs, e_vs, e_bl;
    logic [23:0] e_rgb;

    always @(negedge clock_50) begin
        if (chk_en) begin
            k = n / 2;
            if (n % 2 == 0) held_rgb = prev_rgb;
            ex = 0; ey = 0; e_req = 1'b0; e_fs = 1'b0;
            if (k >= 1) begin
                p     = k - 1;
                ex    = p % HT;
                ey    = (p / HT) % VT;
                e_req = (ex < H_ACTIVE) && (ey < V_ACTIVE);
                e_fs  = (n % 2 == 0) && (p % (HT * VT) == 0);
            end
            e_clk = (n % 2 == 1);
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = '0; dx = -1; dy = -1;
            if (k >= 2) begin
                d    = k - 2;
                dx   = d % HT;
                dy   = (d / HT) % VT;
                e_hs = !(dx >= H_ACTIVE + H_FRONT && dx < H_ACTIVE + H_FRONT + H_SYNC);
                e_vs = !(dy >= V_ACTIVE + V_FRONT && dy < V_ACTIVE + V_FRONT + V_SYNC);
                e_bl = (dx < H_ACTIVE) && (dy < V_ACTIVE);
`ifdef VGA_TEST_PATTERN_EN
                if (e_bl) e_rgb = bar_ref(dx);
`else
                if (e_bl) e_rgb = held_rgb;
`endif
            end
            check($sformatf("model n=%0d", n),
                  64'({pixel_x, pixel_y, pixel_req, frame_start, VGA_CLK, VGA_HS, VGA_VS,
                       VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B}),
                  64'({10'(ex), 10'(ey), e_req, e_fs, e_clk, e_hs, e_vs, e_bl, 1'b0, e_rgb}));
`ifdef VGA_TEST_PATTERN_EN
            if (dy == 1 && dx == 85) begin
                seen_a = 1'b1;
                check("bar_at_85", 64'({VGA_R, VGA_G, VGA_B}), 64'(24'hFFFF00));
            end
            if (dy == 1 && dx == 639) begin
                seen_b = 1'b1;
                check("bar_at_639", 64'({VGA_R, VGA_G, VGA_B}), 64'(24'h000000));
            end
`else
            if (mode == 0 && dx == 10 && dy == 3) begin
                seen_a = 1'b1;
                check("rgb_at_10_3", 64'({VGA_R, VGA_G, VGA_B}), 64'(24'h0A03A5));
            end
            if (mode == 0 && dx == 700 && dy == 3) begin
                seen_b = 1'b1;
                check("rgb_blanked", 64'({VGA_R, VGA_G, VGA_B}), 64'(24'h000000));
            end
`endif
        end
        prev_rgb = rgb_in;
    end

    int t_vis, t_f1, t_r, t_f2, t_fa, t_fb, t_dummy;
    int vs_low, lines, run, rst_len;

    initial begin
        repeat (5) @(posedge clock_50);
        @(negedge clock_50);
        chk_en = 1'b1;
        check("reset_outputs",
              64'({pixel_x, pixel_y, pixel_req, frame_start, VGA_CLK, VGA_BLANK, VGA_SYNC,
                   VGA_R, VGA_G, VGA_B}), 64'(0));
        check("reset_sync", 64'({VGA_HS, VGA_VS}), 64'(2'b11));
        reset = 1'b0;
        @(negedge clock_50);
        check("fs_after_1", 64'(frame_start), 64'(0));
        @(negedge clock_50);
        check("fs_after_2", 64'(frame_start), 64'(1));
        check("start_xy", 64'({pixel_x, pixel_y}), 64'(0));
        @(negedge clock_50);
        check("fs_after_3", 64'(frame_start), 64'(0));

        // one line of horizontal timing
        wait_for(2, 1'b1, 100, "blank_rise", t_vis);
        wait_for(0, 1'b0, 3000, "hs_fall", t_f1);
        wait_for(0, 1'b1, 3000, "hs_rise", t_r);
        wait_for(0, 1'b0, 3000, "hs_fall2", t_f2);
        check("hs_from_visible", 64'(t_f1 - t_vis), 64'(1312));
        check("hs_low", 64'(t_r - t_f1), 64'(192));
        check("hs_period", 64'(t_f2 - t_f1), 64'(1600));

        // one whole frame, random colours from here on
        wait_for(3, 1'b1, 30000, "frame_start_a", t_fa);
        mode = 1;
        vs_low = 0; lines = 0; run = 0;
        @(negedge clock_50);
        for (int i = 0; i < 30000 && frame_start !== 1'b1; i++) begin
            if (!VGA_VS) vs_low++;
            if (VGA_BLANK) run++;
            else if (run != 0) begin
                check("blank_run", 64'(run), 64'(1280));
                lines++;
                run = 0;
            end
            @(negedge clock_50);
        end
        wait_for(3, 1'b1, 1, "frame_start_b", t_fb);
        check("frame_period", 64'(t_fb - t_fa), 64'(2 * HT * VT));
        check("vs_low", 64'(vs_low), 64'(3200));
        check("blank_lines", 64'(lines), 64'(V_ACTIVE));

        // reset in the middle of a frame
        for (int i = 0; i < 30000 && !(pixel_x == 10'd400 && pixel_y == 10'd7); i++)
            @(negedge clock_50);
        check("reached_400_7", 64'({pixel_x, pixel_y}), 64'({10'd400, 10'd7}));
        reset   = 1'b1;
        rst_len = $urandom_range(2, 6);
        repeat (rst_len) @(negedge clock_50);
        reset = 1'b0;
        @(negedge clock_50);
        check("mid_fs_after_1", 64'(frame_start), 64'(0));
        @(negedge clock_50);
        check("mid_fs_after_2", 64'(frame_start), 64'(1));
        check("mid_start_xy", 64'({pixel_x, pixel_y}), 64'(0));
        repeat (4000) @(negedge clock_50);

        check("saw_colour_point_a", 64'(seen_a), 64'(1));
        check("saw_colour_point_b", 64'(seen_b), 64'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
